// File: rtl/fc_pkg.sv
// Fast-control shared definitions: command word layout, run-state encoding, timing constants.
package fc_pkg;

  localparam int unsigned BX_W   = 12;
  localparam int unsigned FC_W   = 4;
  localparam int unsigned RS_W   = 3;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned PER_W  = 16;

  // Bit positions inside the 4-bit fast-control command word
  localparam int unsigned FC_BCR          = 0;
  localparam int unsigned FC_L1A          = 1;
  localparam int unsigned FC_LINK_RESET   = 2;
  localparam int unsigned FC_BUFFER_CLEAR = 3;

  localparam int unsigned L1A_MIN_SPACING    = 4;
  localparam int unsigned L1A_PEND_DEPTH     = 8;
  localparam logic [BX_W-1:0] RESYNC_SLOT    = 12'd20;
  localparam int unsigned RESYNC_WAIT_ORBITS = 4;
  localparam int unsigned CLEAR_HOLDOFF      = 16;

  localparam int unsigned PEND_W = $clog2(L1A_PEND_DEPTH + 1);
  localparam int unsigned SPC_W  = $clog2(L1A_MIN_SPACING + 1);
  localparam int unsigned HOLD_W = $clog2(CLEAR_HOLDOFF + 1);
  localparam int unsigned ORBC_W = $clog2(RESYNC_WAIT_ORBITS + 1);

  typedef enum logic [RS_W-1:0] {
    RS_STOPPED     = 3'd0,
    RS_RESYNC_LR   = 3'd1,
    RS_RESYNC_WAIT = 3'd2,
    RS_RESYNC_BC   = 3'd3,
    RS_RUNNING     = 3'd4
  } run_state_e;

endpackage

// File: rtl/fc_orbit_counter.sv
// Orbit BX counter with registered bunch-crossing-reset flag.
module fc_orbit_counter
  import fc_pkg::*;
(
  input  logic            clk_bx,
  input  logic            reset,
  input  logic [BX_W-1:0] i_orb_length,
  output logic [BX_W-1:0] o_bx_counter,
  output logic            o_bcr
);

  localparam int unsigned BXC_W = BX_W + 1;

  logic [BX_W-1:0]  r_bx;
  logic             r_bcr;
  logic [BXC_W-1:0] w_bx_inc;
  logic             w_wrap;

  // One extra bit so an orbit length of 0 or 1 pins the counter at zero
  assign w_bx_inc = {1'b0, r_bx} + BXC_W'(1);
  assign w_wrap   = (w_bx_inc >= {1'b0, i_orb_length});

  // Advance BX position and flag the crossing that followed BX 0
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      r_bx  <= '0;
      r_bcr <= 1'b0;
    end else begin
      r_bx  <= w_wrap ? '0 : w_bx_inc[BX_W-1:0];
      r_bcr <= (r_bx == '0);
    end
  end

  assign o_bx_counter = r_bx;
  assign o_bcr        = r_bcr;

endmodule

// File: rtl/fc_cmd_scheduler.sv
// Fast-control command scheduler: merges trigger sources with resync commands,
// runs the start-of-run sequence and emits one registered command word per BX.
module fc_cmd_scheduler
  import fc_pkg::*;
(
  input  logic              clk_bx,
  input  logic              reset,
  input  logic [BX_W-1:0]   orb_length,
  input  logic              l1a_ext,
  input  logic              l1a_sw,
  input  logic              periodic_en,
  input  logic [PER_W-1:0]  periodic_period,
  input  logic              link_reset_req,
  input  logic              buffer_clear_req,
  input  logic              run_start,
  input  logic              run_stop,
  input  logic              throttle,
  output logic [BX_W-1:0]   bx_counter,
  output logic [FC_W-1:0]   fc_word,
  output logic [RS_W-1:0]   run_state,
  output logic [DROP_W-1:0] l1a_dropped
);

  run_state_e        r_state;
  run_state_e        w_state_nxt;
  logic [BX_W-1:0]   w_bx;
  logic              w_bcr;

  logic              r_lr_pend;
  logic              r_bc_pend;
  logic [PEND_W-1:0] r_pend_cnt;
  logic [DROP_W-1:0] r_dropped;
  logic [SPC_W-1:0]  r_spacing;
  logic [HOLD_W-1:0] r_holdoff;
  logic [PER_W-1:0]  r_per_cnt;
  logic [ORBC_W-1:0] r_wait_orbits;
  logic              r_fc_l1a;
  logic              r_fc_lr;
  logic              r_fc_bc;

  logic              w_running;
  logic              w_slot;
  logic              w_lr_issue;
  logic              w_bc_issue;
  logic              w_l1a_issue;
  logic              w_per_active;
  logic              w_per_req;
  logic              w_l1a_src;
  logic              w_queue_full;
  logic              w_wait_done;
  logic              w_fsm_lr_req;
  logic              w_fsm_bc_req;
  logic              w_orb_clr;
  logic              w_orb_inc;

  fc_orbit_counter u_orbit (
    .clk_bx       (clk_bx),
    .reset        (reset),
    .i_orb_length (orb_length),
    .o_bx_counter (w_bx),
    .o_bcr        (w_bcr)
  );

  assign w_running    = (r_state == RS_RUNNING);
  assign w_slot       = (w_bx == RESYNC_SLOT);
  assign w_queue_full = (r_pend_cnt == PEND_W'(L1A_PEND_DEPTH));
  assign w_wait_done  = (r_wait_orbits == ORBC_W'(RESYNC_WAIT_ORBITS - 1));

  // Command arbitration: link reset beats buffer clear beats L1A in a BX
  assign w_lr_issue  = r_lr_pend & w_slot;
  assign w_bc_issue  = r_bc_pend & w_slot & ~w_lr_issue;
  assign w_l1a_issue = (r_pend_cnt != '0) & w_running & ~throttle &
                       (r_spacing == '0) & (r_holdoff == '0) &
                       ~w_lr_issue & ~w_bc_issue;

  // Periodic trigger only counts while running with a non-zero period
  assign w_per_active = periodic_en & (periodic_period != '0) & w_running;
  assign w_per_req    = w_per_active & (r_per_cnt == periodic_period - PER_W'(1));
  assign w_l1a_src    = l1a_ext | l1a_sw | w_per_req;

  // Run-state register
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      r_state <= RS_STOPPED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: resync sequence, stop overrides everything including start
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RS_STOPPED:     if (run_start)               w_state_nxt = RS_RESYNC_LR;
      RS_RESYNC_LR:   if (w_lr_issue)              w_state_nxt = RS_RESYNC_WAIT;
      RS_RESYNC_WAIT: if (w_bcr && w_wait_done)    w_state_nxt = RS_RESYNC_BC;
      RS_RESYNC_BC:   if (w_bc_issue)              w_state_nxt = RS_RUNNING;
      RS_RUNNING:                                  w_state_nxt = RS_RUNNING;
      default:                                     w_state_nxt = RS_STOPPED;
    endcase
    if (run_stop) begin
      w_state_nxt = RS_STOPPED;
    end
  end

  // FSM outputs: resync command requests and orbit-count control
  always_comb begin
    w_fsm_lr_req = 1'b0;
    w_fsm_bc_req = 1'b0;
    w_orb_clr    = 1'b0;
    w_orb_inc    = 1'b0;
    if (!run_stop) begin
      case (r_state)
        RS_STOPPED:     w_fsm_lr_req = run_start;
        RS_RESYNC_LR:   w_orb_clr    = w_lr_issue;
        RS_RESYNC_WAIT: begin
          if (w_bcr) begin
            if (w_wait_done) w_fsm_bc_req = 1'b1;
            else             w_orb_inc    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Orbits seen since the resync link reset went out
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      r_wait_orbits <= '0;
    end else if (w_orb_clr) begin
      r_wait_orbits <= '0;
    end else if (w_orb_inc) begin
      r_wait_orbits <= r_wait_orbits + ORBC_W'(1);
    end
  end

  // Sticky resync flags; repeats while pending merge, a stop does not cancel them
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      r_lr_pend <= 1'b0;
      r_bc_pend <= 1'b0;
    end else begin
      r_lr_pend <= (r_lr_pend & ~w_lr_issue) | link_reset_req   | w_fsm_lr_req;
      r_bc_pend <= (r_bc_pend & ~w_bc_issue) | buffer_clear_req | w_fsm_bc_req;
    end
  end

  // Pending L1A queue and saturating drop counter
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      r_pend_cnt <= '0;
      r_dropped  <= '0;
    end else if (r_state == RS_STOPPED) begin
      r_pend_cnt <= '0;
    end else if (w_l1a_src && !w_l1a_issue) begin
      if (w_queue_full) begin
        if (r_dropped != '1) r_dropped <= r_dropped + DROP_W'(1);
      end else begin
        r_pend_cnt <= r_pend_cnt + PEND_W'(1);
      end
    end else if (!w_l1a_src && w_l1a_issue) begin
      r_pend_cnt <= r_pend_cnt - PEND_W'(1);
    end
  end

  // Trigger-rule timers: minimum L1A spacing and post-clear holdoff
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      r_spacing <= '0;
      r_holdoff <= '0;
    end else begin
      if (w_l1a_issue)           r_spacing <= SPC_W'(L1A_MIN_SPACING - 1);
      else if (r_spacing != '0)  r_spacing <= r_spacing - SPC_W'(1);
      if (w_bc_issue)            r_holdoff <= HOLD_W'(CLEAR_HOLDOFF);
      else if (r_holdoff != '0)  r_holdoff <= r_holdoff - HOLD_W'(1);
    end
  end

  // Periodic trigger counter, parked at zero whenever inactive
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      r_per_cnt <= '0;
    end else if (!w_per_active || w_per_req) begin
      r_per_cnt <= '0;
    end else begin
      r_per_cnt <= r_per_cnt + PER_W'(1);
    end
  end

  // Registered command bits
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      r_fc_l1a <= 1'b0;
      r_fc_lr  <= 1'b0;
      r_fc_bc  <= 1'b0;
    end else begin
      r_fc_l1a <= w_l1a_issue;
      r_fc_lr  <= w_lr_issue;
      r_fc_bc  <= w_bc_issue;
    end
  end

  assign fc_word[FC_BCR]          = w_bcr;
  assign fc_word[FC_L1A]          = r_fc_l1a;
  assign fc_word[FC_LINK_RESET]   = r_fc_lr;
  assign fc_word[FC_BUFFER_CLEAR] = r_fc_bc;
  assign bx_counter               = w_bx;
  assign run_state                = r_state;
  assign l1a_dropped              = r_dropped;

endmodule

// File: tb/tb_fc_cmd_scheduler.sv
// Scoreboard bench for fc_cmd_scheduler: expected commands (type, BX) are queued
// with the stimulus and a negedge monitor pops them as fc_word presents commands.
module tb_fc_cmd_scheduler;

  logic        clk_bx = 1'b0;
  logic        reset;
  logic [11:0] orb_length;
  logic        l1a_ext, l1a_sw, periodic_en;
  logic [15:0] periodic_period;
  logic        link_reset_req, buffer_clear_req, run_start, run_stop, throttle;
  logic [11:0] bx_counter;
  logic [3:0]  fc_word;
  logic [2:0]  run_state;
  logic [15:0] l1a_dropped;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected command: {fc_word[3:1], bx_counter at the BX it appears}
  logic [14:0] exp_q[$];
  logic [14:0] mon_got, mon_want;

  localparam logic [2:0] C_BC  = 3'b100;
  localparam logic [2:0] C_LR  = 3'b010;
  localparam logic [2:0] C_L1A = 3'b001;

  fc_cmd_scheduler dut (
    .clk_bx           (clk_bx),
    .reset            (reset),
    .orb_length       (orb_length),
    .l1a_ext          (l1a_ext),
    .l1a_sw           (l1a_sw),
    .periodic_en      (periodic_en),
    .periodic_period  (periodic_period),
    .link_reset_req   (link_reset_req),
    .buffer_clear_req (buffer_clear_req),
    .run_start        (run_start),
    .run_stop         (run_stop),
    .throttle         (throttle),
    .bx_counter       (bx_counter),
    .fc_word          (fc_word),
    .run_state        (run_state),
    .l1a_dropped      (l1a_dropped)
  );

  always #5 clk_bx = ~clk_bx;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every command on fc_word must match the head of the queue
  always @(negedge clk_bx) begin
    if (!reset && fc_word[3:1] != 3'b000) begin
      mon_got = {fc_word[3:1], bx_counter};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL cmd_unexpected: got cmd=%b bx=%0d, required no command", fc_word[3:1], bx_counter);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got != mon_want) begin
          n_fail++;
          $display("FAIL cmd_seq: got cmd=%b bx=%0d, required cmd=%b bx=%0d",
                   mon_got[14:12], mon_got[11:0], mon_want[14:12], mon_want[11:0]);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [2:0] cmd, input int bx);
    exp_q.push_back({cmd, 12'(bx)});
  endtask

  task automatic wait_bx(input int b);
    int n = 0;
    @(negedge clk_bx);
    while (int'(bx_counter) != b && n < 200) begin
      @(negedge clk_bx);
      n++;
    end
    check($sformatf("wait_bx_%0d", b), int'(bx_counter), b);
  endtask

  task automatic wait_state(input int s);
    int n = 0;
    @(negedge clk_bx);
    while (int'(run_state) != s && n < 300) begin
      @(negedge clk_bx);
      n++;
    end
    check($sformatf("wait_state_%0d", s), int'(run_state), s);
  endtask

  initial begin
    int prev_bcr;
    int bcr_cnt;
    reset = 1'b1; orb_length = 12'd45;
    l1a_ext = 0; l1a_sw = 0; periodic_en = 0; periodic_period = 16'd0;
    link_reset_req = 0; buffer_clear_req = 0; run_start = 0; run_stop = 0; throttle = 0;

    // Reset state
    repeat (3) @(negedge clk_bx);
    check("rst_bx", int'(bx_counter), 0);
    check("rst_fc", int'(fc_word), 0);
    check("rst_state", int'(run_state), 0);
    check("rst_dropped", int'(l1a_dropped), 0);
    reset = 1'b0;

    // Orbit of 45: BCR seen at bx 1 (one BX after bx 0), every 45 BX
    prev_bcr = -1; bcr_cnt = 0;
    for (int i = 1; i <= 135; i++) begin
      @(negedge clk_bx);
      if (fc_word[0]) begin
        check("bcr_bx", int'(bx_counter), 1);
        if (prev_bcr >= 0) check("bcr_gap", i - prev_bcr, 45);
        prev_bcr = i;
        bcr_cnt++;
      end
    end
    check("bcr_count", bcr_cnt, 3);

    // Orbit of 1: counter pinned at 0, BCR every BX
    orb_length = 12'd1;
    @(negedge clk_bx);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_bx);
      check("orb1_bcr", int'(fc_word[0]), 1);
      check("orb1_bx", int'(bx_counter), 0);
    end
    orb_length = 12'd45;

    // Start of run at bx 30: LR at next slot, BC four orbits later, then RUNNING
    wait_bx(30);
    run_start = 1;
    push(C_LR, 21); push(C_BC, 21);
    @(negedge clk_bx);
    run_start = 0;
    check("start_state", int'(run_state), 1);
    wait_state(2);
    check("lr_bx", int'(bx_counter), 21);
    wait_state(3);
    check("wait_done_bx", int'(bx_counter), 2);
    wait_state(4);
    check("run_bx", int'(bx_counter), 21);
    check("run_bc_bit", int'(fc_word[3]), 1);

    // Three SW triggers right away: holdoff delays the first, then spacing 4
    push(C_L1A, 38); push(C_L1A, 42); push(C_L1A, 1);
    l1a_sw = 1;
    repeat (3) @(negedge clk_bx);
    l1a_sw = 0;

    // Throttled burst of 10: queue saturates at 8, two dropped
    wait_bx(5);
    throttle = 1; l1a_ext = 1;
    repeat (10) @(negedge clk_bx);
    l1a_ext = 0;
    check("dropped_2", int'(l1a_dropped), 2);
    check("pend_8", int'(dut.r_pend_cnt), 8);
    for (int k = 0; k < 8; k++) push(C_L1A, 3 + 4 * k);
    wait_bx(2);
    throttle = 0;
    wait_bx(35);

    // Link reset and a queued L1A both ready at bx 20: LR first, L1A next BX
    wait_bx(5);
    link_reset_req = 1;
    @(negedge clk_bx);
    link_reset_req = 0;
    wait_bx(19);
    l1a_ext = 1;
    push(C_LR, 21); push(C_L1A, 22);
    @(negedge clk_bx);
    l1a_ext = 0;

    // Stop from RUNNING
    wait_bx(25);
    check("manual_lr_state", int'(run_state), 4);
    run_stop = 1;
    @(negedge clk_bx);
    run_stop = 0;
    check("stop_state", int'(run_state), 0);
    check("stop_dropped_kept", int'(l1a_dropped), 2);

    // Restart, then stop+start together while in RESYNC_WAIT
    wait_bx(30);
    run_start = 1;
    push(C_LR, 21);
    @(negedge clk_bx);
    run_start = 0;
    wait_state(2);
    l1a_ext = 1;
    repeat (2) @(negedge clk_bx);
    l1a_ext = 0;
    check("wait_pend_2", int'(dut.r_pend_cnt), 2);
    run_stop = 1; run_start = 1;
    @(negedge clk_bx);
    run_stop = 0; run_start = 0;
    check("stop_wins_state", int'(run_state), 0);
    @(negedge clk_bx);
    check("stopped_pend_0", int'(dut.r_pend_cnt), 0);

    // Full resync again, then periodic generator with period 10
    wait_bx(30);
    run_start = 1;
    push(C_LR, 21); push(C_BC, 21);
    @(negedge clk_bx);
    run_start = 0;
    wait_state(3);
    check("wait_done_bx2", int'(bx_counter), 2);
    wait_state(4);
    check("run_bx2", int'(bx_counter), 21);
    wait_bx(0);
    periodic_en = 1; periodic_period = 16'd10;
    push(C_L1A, 11); push(C_L1A, 21); push(C_L1A, 31);
    wait_bx(33);
    periodic_en = 0;

    // Asynchronous reset mid-RUNNING with a queued trigger
    wait_bx(40);
    throttle = 1; l1a_ext = 1;
    @(negedge clk_bx);
    l1a_ext = 0;
    reset = 1;
    #1;
    check("async_rst_bx", int'(bx_counter), 0);
    check("async_rst_fc", int'(fc_word), 0);
    check("async_rst_state", int'(run_state), 0);
    check("async_rst_dropped", int'(l1a_dropped), 0);
    repeat (3) @(negedge clk_bx);
    reset = 0; throttle = 0;
    repeat (60) @(negedge clk_bx);
    check("post_rst_state", int'(run_state), 0);
    check("post_rst_pend", int'(dut.r_pend_cnt), 0);

    // Every expected command must have been seen
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
